// File: rtl/apbif_regbank.sv
`default_nettype none
// ============================================================================
// Module   : apbif_regbank
// Purpose  : APB3 slave register bank. It provides NUM_RW config words and
//            mirrors NUM_RO core status words. It also has a self-clearing
//            CTRL word (START / SRESET pulses) and a masked W1C interrupt
//            block that drives a registered IRQ line. Programmable wait
//            states and PSLVERR are supported.
// Options  : APBIF_PSTRB_EN - adds I_APBIF_PSTRB byte-lane write qualification.
// Revision : 1.0 - initial release
// ============================================================================
module apbif_regbank #(
  parameter int NUM_RW      = 6,
  parameter int NUM_RO      = 2,
  parameter int NUM_IRQ     = 4,
  parameter int WAIT_STATES = 0,
  parameter int ADDR_W      = 8
) (
  input  logic                  I_APBIF_PCLK,
  input  logic                  I_APBIF_PRESET_N,
  input  logic                  I_APBIF_PSEL,
  input  logic                  I_APBIF_PENABLE,
  input  logic                  I_APBIF_PWRITE,
  input  logic [ADDR_W-1:0]     I_APBIF_PADDR,
  input  logic [31:0]           I_APBIF_PWDATA,
`ifdef APBIF_PSTRB_EN
  input  logic [3:0]            I_APBIF_PSTRB,
`endif
  input  logic [NUM_RO*32-1:0]  I_APBIF_STATUS,
  input  logic [NUM_IRQ-1:0]    I_APBIF_INTR_EVT,
  output logic [31:0]           O_APBIF_PRDATA,
  output logic                  O_APBIF_PREADY,
  output logic                  O_APBIF_PSLVERR,
  output logic [NUM_RW*32-1:0]  O_APBIF_CFG,
  output logic                  O_APBIF_CTRL_START,
  output logic                  O_APBIF_CTRL_RESET,
  output logic                  O_APBIF_IRQ
);

  // Word indices of the special registers that follow the RW and RO blocks.
  localparam int         BASE      = NUM_RW + NUM_RO;
  localparam logic [31:0] C_CTRL_IDX = 32'(BASE);
  localparam logic [31:0] C_STAT_IDX = 32'(BASE + 1);
  localparam logic [31:0] C_MASK_IDX = 32'(BASE + 2);
  localparam logic [3:0]  C_WAIT_LAST = 4'(WAIT_STATES);

  // --------------------------------------------------------------------------
  // Handshake
  // --------------------------------------------------------------------------
  logic        access;
  logic        ready;
  logic [3:0]  wait_cnt;

  assign access = I_APBIF_PSEL & I_APBIF_PENABLE;
  // PREADY is held low while reset is asserted, so every output reads 0 during reset.
  assign ready  = access & (wait_cnt == C_WAIT_LAST) & I_APBIF_PRESET_N;

  // Count ACCESS cycles; restart on completion or whenever the slave is deselected.
  always_ff @(posedge I_APBIF_PCLK or negedge I_APBIF_PRESET_N) begin
    if (!I_APBIF_PRESET_N) begin
      wait_cnt <= '0;
    end else if (!I_APBIF_PSEL || ready) begin
      wait_cnt <= '0;
    end else if (access) begin
      wait_cnt <= wait_cnt + 4'd1;
    end
  end

  // --------------------------------------------------------------------------
  // Address decode
  // --------------------------------------------------------------------------
  logic [31:0] widx;
  logic        hit_rw;
  logic        hit_ro;
  logic        hit_ctrl;
  logic        hit_stat;
  logic        hit_mask;
  logic        unmapped;
  logic        access_err;
  logic        do_commit;
  logic        unused_addr_lsb;

  assign widx     = 32'(I_APBIF_PADDR[ADDR_W-1:2]);
  assign hit_rw   = (widx < 32'(NUM_RW));
  assign hit_ro   = (widx >= 32'(NUM_RW)) && (widx < 32'(BASE));
  assign hit_ctrl = (widx == C_CTRL_IDX);
  assign hit_stat = (widx == C_STAT_IDX);
  assign hit_mask = (widx == C_MASK_IDX);
  assign unmapped = ~(hit_rw | hit_ro | hit_ctrl | hit_stat | hit_mask);

  // An error means either a write to a read-only status word or an access to a hole in the map.
  assign access_err = unmapped | (hit_ro & I_APBIF_PWRITE);
  assign do_commit  = ready & I_APBIF_PWRITE & ~access_err;

  // The byte offset is not decoded. Keep it named so that it is visibly intentional.
  assign unused_addr_lsb = ^I_APBIF_PADDR[1:0];

  // --------------------------------------------------------------------------
  // Byte-lane qualification
  // --------------------------------------------------------------------------
  logic [3:0]  be;
  logic [31:0] bmask;

`ifdef APBIF_PSTRB_EN
  assign be = I_APBIF_PSTRB;
`else
  assign be = 4'hF;
`endif

  assign bmask = {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};

  // --------------------------------------------------------------------------
  // Config registers
  // --------------------------------------------------------------------------
  logic [NUM_RW*32-1:0] cfg_q;

  for (genvar i = 0; i < NUM_RW; i++) begin : g_rw
    // Merge the enabled byte lanes of PWDATA into config word i on commit.
    always_ff @(posedge I_APBIF_PCLK or negedge I_APBIF_PRESET_N) begin
      if (!I_APBIF_PRESET_N) begin
        cfg_q[32*i +: 32] <= '0;
      end else if (do_commit && hit_rw && (widx == 32'(i))) begin
        cfg_q[32*i +: 32] <= (cfg_q[32*i +: 32] & ~bmask) | (I_APBIF_PWDATA & bmask);
      end
    end
  end

  // --------------------------------------------------------------------------
  // Control pulses
  // --------------------------------------------------------------------------
  logic ctrl_start_q;
  logic ctrl_reset_q;
  logic ctrl_wr;

  assign ctrl_wr = do_commit & hit_ctrl & be[0];

  // A CTRL write produces one-cycle pulses. The bits are never stored.
  always_ff @(posedge I_APBIF_PCLK or negedge I_APBIF_PRESET_N) begin
    if (!I_APBIF_PRESET_N) begin
      ctrl_start_q <= 1'b0;
      ctrl_reset_q <= 1'b0;
    end else begin
      ctrl_start_q <= ctrl_wr & I_APBIF_PWDATA[0];
      ctrl_reset_q <= ctrl_wr & I_APBIF_PWDATA[1];
    end
  end

  // --------------------------------------------------------------------------
  // Interrupt block
  // --------------------------------------------------------------------------
  logic [NUM_IRQ-1:0] stat_q;
  logic [NUM_IRQ-1:0] mask_q;
  logic [NUM_IRQ-1:0] stat_clr;
  logic               irq_q;

  // Sources that clear status bits: a W1C write, or the soft-reset pulse, which clears everything.
  always_comb begin
    stat_clr = '0;
    if (do_commit && hit_stat && be[0]) begin
      stat_clr = I_APBIF_PWDATA[NUM_IRQ-1:0];
    end
    if (ctrl_reset_q) begin
      stat_clr = '1;
    end
  end

  // Events are ORed in after the clear is applied, so a new event wins over a simultaneous clear.
  always_ff @(posedge I_APBIF_PCLK or negedge I_APBIF_PRESET_N) begin
    if (!I_APBIF_PRESET_N) begin
      stat_q <= '0;
    end else begin
      stat_q <= (stat_q & ~stat_clr) | I_APBIF_INTR_EVT;
    end
  end

  // Interrupt enable mask, writable per byte lane.
  always_ff @(posedge I_APBIF_PCLK or negedge I_APBIF_PRESET_N) begin
    if (!I_APBIF_PRESET_N) begin
      mask_q <= '0;
    end else if (do_commit && hit_mask) begin
      mask_q <= (mask_q & ~bmask[NUM_IRQ-1:0]) | (I_APBIF_PWDATA[NUM_IRQ-1:0] & bmask[NUM_IRQ-1:0]);
    end
  end

  // Registered IRQ, one cycle behind the status and mask registers.
  always_ff @(posedge I_APBIF_PCLK or negedge I_APBIF_PRESET_N) begin
    if (!I_APBIF_PRESET_N) begin
      irq_q <= 1'b0;
    end else begin
      irq_q <= |(stat_q & mask_q);
    end
  end

  // --------------------------------------------------------------------------
  // Read path
  // --------------------------------------------------------------------------
  logic [31:0] rd_word;

  // Select the addressed word. CTRL and unmapped words read 0.
  always_comb begin
    rd_word = '0;
    for (int k = 0; k < NUM_RW; k++) begin
      if (widx == 32'(k)) begin
        rd_word = cfg_q[32*k +: 32];
      end
    end
    for (int k = 0; k < NUM_RO; k++) begin
      if (widx == 32'(NUM_RW + k)) begin
        rd_word = I_APBIF_STATUS[32*k +: 32];
      end
    end
    if (hit_stat) begin
      rd_word[NUM_IRQ-1:0] = stat_q;
    end
    if (hit_mask) begin
      rd_word[NUM_IRQ-1:0] = mask_q;
    end
  end

  assign O_APBIF_PRDATA     = (ready && !access_err) ? rd_word : 32'h0;
  assign O_APBIF_PREADY     = ready;
  assign O_APBIF_PSLVERR    = ready & access_err;
  assign O_APBIF_CFG        = cfg_q;
  assign O_APBIF_CTRL_START = ctrl_start_q;
  assign O_APBIF_CTRL_RESET = ctrl_reset_q;
  assign O_APBIF_IRQ        = irq_q;

endmodule
`default_nettype wire

// File: tb/tb_apbif_regbank.sv
`default_nettype none
// ============================================================================
// Module   : tb_apbif_regbank
// Purpose  : Scoreboard testbench for apbif_regbank (WAIT_STATES = 3). The
//            driver predicts each APB response from a register-map model and
//            queues it. A negedge monitor pops and compares the queued
//            response on every completed transfer.
// Revision : 1.0 - initial release
// ============================================================================
module tb_apbif_regbank;

  localparam int NUM_RW  = 6;
  localparam int NUM_RO  = 2;
  localparam int NUM_IRQ = 4;
  localparam int WS      = 3;
  localparam int ADDR_W  = 8;
  localparam int B       = NUM_RW + NUM_RO;

  logic                  clk = 1'b0;
  logic                  rst_n = 1'b0;
  logic                  psel = 1'b0;
  logic                  penable = 1'b0;
  logic                  pwrite = 1'b0;
  logic [ADDR_W-1:0]     paddr = '0;
  logic [31:0]           pwdata = '0;
`ifdef APBIF_PSTRB_EN
  logic [3:0]            pstrb = 4'hF;
`endif
  logic [NUM_RO*32-1:0]  status = '0;
  logic [NUM_IRQ-1:0]    evt = '0;
  logic [31:0]           prdata;
  logic                  pready;
  logic                  pslverr;
  logic [NUM_RW*32-1:0]  cfg;
  logic                  start;
  logic                  sreset;
  logic                  irq;

  always #5 clk = ~clk;

  apbif_regbank #(
    .NUM_RW(NUM_RW), .NUM_RO(NUM_RO), .NUM_IRQ(NUM_IRQ),
    .WAIT_STATES(WS), .ADDR_W(ADDR_W)
  ) dut (
    .I_APBIF_PCLK(clk),
    .I_APBIF_PRESET_N(rst_n),
    .I_APBIF_PSEL(psel),
    .I_APBIF_PENABLE(penable),
    .I_APBIF_PWRITE(pwrite),
    .I_APBIF_PADDR(paddr),
    .I_APBIF_PWDATA(pwdata),
`ifdef APBIF_PSTRB_EN
    .I_APBIF_PSTRB(pstrb),
`endif
    .I_APBIF_STATUS(status),
    .I_APBIF_INTR_EVT(evt),
    .O_APBIF_PRDATA(prdata),
    .O_APBIF_PREADY(pready),
    .O_APBIF_PSLVERR(pslverr),
    .O_APBIF_CFG(cfg),
    .O_APBIF_CTRL_START(start),
    .O_APBIF_CTRL_RESET(sreset),
    .O_APBIF_IRQ(irq)
  );

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic        chk_rd;
    logic [31:0] rd;
    logic        err;
  } exp_t;

  exp_t sb_q[$];

  // Register-map model.
  logic [31:0]        cfg_m [NUM_RW];
  logic [NUM_IRQ-1:0] stat_m;
  logic [NUM_IRQ-1:0] mask_m;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_cfg();
    for (int k = 0; k < NUM_RW; k++)
      chk($sformatf("cfg%0d", k), cfg[32*k +: 32], cfg_m[k]);
  endtask

  task automatic model_reset();
    for (int k = 0; k < NUM_RW; k++) cfg_m[k] = '0;
    stat_m = '0;
    mask_m = '0;
  endtask

  // Monitor: counts wait cycles and checks every completed transfer against the queue.
  initial begin : monitor
    int waits;
    exp_t e;
    waits = 0;
    forever begin
      @(negedge clk);
      if (!rst_n || !psel) begin
        waits = 0;
      end else if (penable && !pready) begin
        waits++;
      end else if (penable && pready) begin
        if (sb_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL sb_underflow: completion with empty scoreboard at %0t", $time);
        end else begin
          e = sb_q.pop_front();
          chk("wait_cycles", 32'(waits), 32'(WS));
          chk("pslverr", {31'b0, pslverr}, {31'b0, e.err});
          if (e.chk_rd) chk("prdata", prdata, e.rd);
        end
        waits = 0;
      end
    end
  end

  // One APB transfer, starting at posedge+1. evt_c is driven during the ready cycle.
  task automatic xfer(input bit wr, input int w, input logic [31:0] wd,
                      input logic [NUM_IRQ-1:0] evt_c);
    exp_t e;
    bit   err;
    bit   done;
    logic [31:0] rd;
    int   n;
    err = (wr && w >= NUM_RW && w < B) || (w > B + 2);
    rd  = '0;
    if (!err && !wr) begin
      if (w < NUM_RW)      rd = cfg_m[w];
      else if (w < B)      rd = status[32*(w-NUM_RW) +: 32];
      else if (w == B + 1) rd = 32'(stat_m);
      else if (w == B + 2) rd = 32'(mask_m);
    end
    e.chk_rd = !wr;
    e.rd     = rd;
    e.err    = err;
    sb_q.push_back(e);
    psel = 1'b1; penable = 1'b0; pwrite = wr;
    paddr = ADDR_W'(w * 4 + int'($urandom_range(0, 3)));
    pwdata = wd;
    @(posedge clk); #1;
    penable = 1'b1;
    n = 0;
    done = 0;
    while (!done && n < 20) begin
      @(negedge clk);
      if (pready) done = 1;
      else n++;
    end
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL pready_timeout: pready low for %0d access cycles, expected %0d", n, WS);
      void'(sb_q.pop_back());
    end else begin
      evt = evt_c;
    end
    @(posedge clk); #1;
    evt = '0; psel = 1'b0; penable = 1'b0;
    if (done) begin
      stat_m = stat_m | evt_c;
      if (wr && !err) begin
        if (w < NUM_RW) cfg_m[w] = wd;
        else if (w == B + 1) stat_m = (stat_m & ~wd[NUM_IRQ-1:0]) | evt_c;
        else if (w == B + 2) mask_m = wd[NUM_IRQ-1:0];
        else if (w == B && wd[1]) stat_m = '0;
      end
    end
  endtask

  task automatic pulse_evt(input logic [NUM_IRQ-1:0] v);
    evt = v;
    @(posedge clk); #1;
    evt = '0;
    stat_m = stat_m | v;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin : stim
    logic [31:0] snap;
    model_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk); #1;
    chk("rst_pready", {31'b0, pready}, 32'h0);
    chk("rst_pslverr", {31'b0, pslverr}, 32'h0);
    chk("rst_prdata", prdata, 32'h0);
    chk("rst_irq", {31'b0, irq}, 32'h0);
    chk("rst_pulses", {30'b0, start, sreset}, 32'h0);
    chk_cfg();
    rst_n = 1'b1;
    idle(1);

    // Basic write/readback of word 0.
    xfer(1, 0, 32'hDEADBEEF, '0);
    chk("cfg0_after_commit", cfg[31:0], 32'hDEADBEEF);
    xfer(0, 0, 32'h0, '0);
    xfer(0, 1, 32'h0, '0);
    xfer(1, 1, 32'h12345678, '0);
    xfer(0, 1, 32'h0, '0);

    // Abandon a write to word 1 by dropping PSEL in the second wait cycle.
    psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 8'h04; pwdata = 32'hFFFF0000;
    @(posedge clk); #1;
    penable = 1'b1;
    @(posedge clk); #1;
    psel = 1'b0; penable = 1'b0;
    idle(2);
    chk("abandon_cfg1", cfg[63:32], 32'h12345678);

    // RO write, RO read, unmapped read.
    status = {$urandom, $urandom};
    snap = status[31:0];
    xfer(1, NUM_RW, 32'hA5A5A5A5, '0);
    chk("ro_status_kept", status[31:0], snap);
    chk_cfg();
    xfer(0, NUM_RW, 32'h0, '0);
    xfer(0, B + 3, 32'h0, '0);

    // CTRL: both pulses for exactly one cycle, and a readback of 0.
    xfer(1, B, 32'h3, '0);
    chk("ctrl_pulse_hi", {30'b0, start, sreset}, 32'h3);
    idle(1);
    chk("ctrl_pulse_lo", {30'b0, start, sreset}, 32'h0);
    xfer(0, B, 32'h0, '0);

    // Interrupts.
    xfer(1, B + 2, 32'h1, '0);
    pulse_evt(4'h3);
    chk("irq_lag", {31'b0, irq}, 32'h0);
    idle(1);
    chk("irq_set", {31'b0, irq}, 32'h1);
    xfer(0, B + 1, 32'h0, '0);
    xfer(1, B + 1, 32'h1, 4'h1);
    xfer(0, B + 1, 32'h0, '0);
    xfer(1, B + 1, 32'h1, '0);
    xfer(0, B + 1, 32'h0, '0);
    idle(2);
    chk("irq_clear", {31'b0, irq}, 32'h0);

    // Randomised traffic against the model.
    for (int it = 0; it < 80; it++) begin
      int w;
      bit wr;
      logic [NUM_IRQ-1:0] ev;
      w  = ($urandom_range(0, 7) == 0) ? int'($urandom_range(B + 3, 63)) : int'($urandom_range(0, B + 2));
      wr = 1'($urandom_range(0, 1));
      ev = ($urandom_range(0, 3) == 0) ? NUM_IRQ'($urandom) : '0;
      if ($urandom_range(0, 5) == 0) status = {$urandom, $urandom};
      xfer(wr, w, $urandom, ev);
      if ($urandom_range(0, 4) == 0) pulse_evt(NUM_IRQ'($urandom));
      if ($urandom_range(0, 3) == 0) begin
        idle(2);
        chk("rand_irq", {31'b0, irq}, {31'b0, |(stat_m & mask_m)});
        chk_cfg();
      end
    end

    // Asynchronous reset in the middle of ACCESS with live state.
    xfer(1, B + 2, 32'hF, '0);
    xfer(1, 2, 32'hCAFEF00D, '0);
    pulse_evt(4'h5);
    idle(2);
    chk("pre_rst_irq", {31'b0, irq}, 32'h1);
    psel = 1'b1; penable = 1'b0; pwrite = 1'b0; paddr = 8'h08;
    @(posedge clk); #1;
    penable = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    chk("arst_pready", {31'b0, pready}, 32'h0);
    chk("arst_pslverr", {31'b0, pslverr}, 32'h0);
    chk("arst_prdata", prdata, 32'h0);
    chk("arst_irq", {31'b0, irq}, 32'h0);
    chk("arst_pulses", {30'b0, start, sreset}, 32'h0);
    model_reset();
    chk_cfg();
    psel = 1'b0; penable = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    idle(1);
    xfer(0, B + 1, 32'h0, '0);
    xfer(0, B + 2, 32'h0, '0);
    xfer(1, 2, 32'h0BADCAFE, '0);
    xfer(0, 2, 32'h0, '0);
    chk_cfg();

    idle(3);
    chk("sb_drained", 32'(sb_q.size()), 32'h0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Hard time limit so the run always ends.
  initial begin
    #200000;
    errors++;
    $display("FAIL global_timeout: simulation did not finish");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
